output_port_ctrl: RTL and testbench
===================================

OUTPUT_PORT_CTRL -- requirements
Module: output_port_ctrl

Interface
REQ-001 SHALL have parameter FW, default 64: flit width in bits.
REQ-002 SHALL have parameter P, default 7: number of router ports, which is also the number of requesting input queues.
REQ-003 SHALL have parameter B, default 4: log2 of the downstream input buffer depth; CREDITS = 2**B.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port req_in, input, P bits: bit i is input queue i requesting this output port (its dest_port_req bit for this port).
REQ-007 SHALL have port flit_in, input, P*FW bits: slice [i*FW +: FW] is input queue i's flit_to_crossbar.
REQ-008 SHALL have port grant, output, P bits: one-hot or zero grant to the input queues, feeding their grant_dest_port bit for this port.
REQ-009 SHALL have port flit_out_wr, output, 1 bit: flit valid toward the downstream input queue's flit_in_wr.
REQ-010 SHALL have port flit_out, output, FW bits: flit toward the downstream flit_in.
REQ-011 SHALL have port credit_in, input, 1 bit: downstream flit_rel, one pulse per flit freed.
REQ-012 SHALL have port credit_cnt, output, B+1 bits: current credit count.
REQ-013 SHALL have port credit_err, output, 1 bit: sticky credit-overflow flag.

Function
REQ-014 SHALL assert grant combinationally in the same cycle as req_in, because requesting queues sample grant in that cycle.
REQ-015 SHALL assert at most one grant bit per cycle.
REQ-016 SHALL grant only when credit_cnt != 0 and req_in != 0; otherwise grant SHALL be all zero.
REQ-017 SHALL select the winner round-robin: search starts at index rr_ptr and wraps P-1 to 0; the first requesting index wins.
REQ-018 SHALL update rr_ptr on every cycle with a grant to (winner+1), wrapping P-1 to 0; with no grant, rr_ptr is unchanged.
REQ-019 SHALL register flit_out <= flit_in slice of the winner and flit_out_wr <= 1 in a cycle with a grant, for a latency of 1 cycle.
REQ-020 SHALL set flit_out_wr <= 0 and hold flit_out in a cycle without a grant.
REQ-021 SHALL update credit_cnt as follows: grant only -> minus 1; credit_in only -> plus 1; both in the same cycle -> unchanged; neither -> unchanged.
REQ-022 SHALL never let credit_cnt underflow; REQ-016 guarantees this.
REQ-023 SHALL, on credit_in with credit_cnt == CREDITS and no grant, leave credit_cnt at CREDITS and set credit_err to 1 until reset.
REQ-024 SHALL not block grants while credit_err is set.
REQ-025 SHALL treat multicast as independent: the same input queue may also receive grants from other output ports in the same cycle, and this block SHALL impose no coupling between ports.

Reset
REQ-026 SHALL, while rst is asserted (asynchronously), force: credit_cnt = CREDITS, rr_ptr = 0, flit_out_wr = 0, flit_out = 0, credit_err = 0.
REQ-027 SHALL force grant to 0 while rst is asserted.
REQ-028 SHALL return to the full credit count after reset deasserts mid-transfer; the downstream buffer SHALL be reset simultaneously on the same rst.

Structure
REQ-029 SHALL take FW, P, B, CREDITS and the flit field offsets (R_FLG = 36, X_FLG = 48) from the shared NoC package/header used by the input queue.
REQ-030 SHALL implement the round-robin search in sub-module rr_arbiter (parameter P; inputs: req, ptr, en; output: one-hot gnt).
REQ-031 SHALL keep credit counting and output registers in output_port_ctrl.

Verification
REQ-032 SHALL cover: after reset, req_in = 7'b0000100 -> grant = 7'b0000100 in that cycle; the next cycle flit_out = slice 2 and flit_out_wr = 1; credit_cnt = 15.
REQ-033 SHALL cover: req_in = 7'b1000001 held steady, rr_ptr = 0 -> grants alternate 0, 6, 0, 6 over four cycles.
REQ-034 SHALL cover: 16 grants with no credit_in -> credit_cnt = 0, grant = 0 while req_in != 0; one credit_in -> exactly one further grant.
REQ-035 SHALL cover: grant and credit_in in the same cycle at credit_cnt = 5 -> credit_cnt stays 5.
REQ-036 SHALL cover: credit_in at credit_cnt = 16 with no grant -> credit_cnt = 16 and credit_err = 1, sticky until rst.
REQ-037 SHALL cover: rst asserted mid-stream, asynchronously between edges -> flit_out_wr = 0, grant = 0 and credit_cnt = 16 immediately.

Source files
------------

// File: rtl/output_port_ctrl_pkg.sv
// Shared NoC constants for the output port controller.
// Flit geometry and buffer sizing match the input queue.
package output_port_ctrl_pkg;

  localparam int NOC_FW      = 64;
  localparam int NOC_P       = 7;
  localparam int NOC_B       = 4;
  localparam int NOC_CREDITS = 2 ** NOC_B;
  localparam int R_FLG       = 36;
  localparam int X_FLG       = 48;

  function automatic int ptr_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/output_port_ctrl_if.sv
// Bus between the input queues, this output port and the
// downstream input buffer.
interface output_port_ctrl_if
  import output_port_ctrl_pkg::*;
#(
  parameter int FW = NOC_FW,
  parameter int P  = NOC_P,
  parameter int B  = NOC_B
);

  logic [P-1:0]    req_in;
  logic [P*FW-1:0] flit_in;
  logic [P-1:0]    grant;
  logic            flit_out_wr;
  logic [FW-1:0]   flit_out;
  logic            credit_in;
  logic [B:0]      credit_cnt;
  logic            credit_err;

  modport master (
    output req_in,
    output flit_in,
    output credit_in,
    input  grant,
    input  flit_out_wr,
    input  flit_out,
    input  credit_cnt,
    input  credit_err
  );

  modport slave (
    input  req_in,
    input  flit_in,
    input  credit_in,
    output grant,
    output flit_out_wr,
    output flit_out,
    output credit_cnt,
    output credit_err
  );

endinterface

// File: rtl/output_port_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins,
// wrapping P-1 to 0. One-hot or zero grant.
module rr_arbiter
  import output_port_ctrl_pkg::*;
#(
  parameter int P = NOC_P
) (
  input  logic [P-1:0]        req,
  input  logic [ptr_w(P)-1:0] ptr,
  input  logic                en,
  output logic [P-1:0]        gnt
);

  localparam int PW = ptr_w(P);
  localparam logic [PW:0] PN = (PW+1)'(P);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < P; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= PN)
        idx = idx - PN;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_ctrl.sv
// Output port controller: round-robin grant, one-cycle flit
// register and credit tracking toward the downstream buffer.
module output_port_ctrl
  import output_port_ctrl_pkg::*;
#(
  parameter int FW = NOC_FW,
  parameter int P  = NOC_P,
  parameter int B  = NOC_B
) (
  input logic               clk,
  input logic               rst,
  output_port_ctrl_if.slave bus
);

  localparam int PW = ptr_w(P);
  localparam int CREDITS = 2 ** B;
  localparam logic [B:0] CFULL = (B+1)'(CREDITS);
  localparam logic [PW-1:0] PLAST = PW'(P - 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt_ptr;
  logic [P-1:0]  gnt;
  logic          any_gnt;
  logic          en;
  logic [FW-1:0] sel_flit;
  logic [FW-1:0] flit_q;
  logic          wr_q;
  logic [B:0]    cnt_q;
  logic          err_q;

  // rst gates en so grant drops the moment reset asserts
  assign en = !rst && (cnt_q != '0);

  rr_arbiter #(.P(P)) u_arb (
    .req (bus.req_in),
    .ptr (rr_ptr),
    .en  (en),
    .gnt (gnt)
  );

  assign any_gnt = |gnt;

  always_comb begin
    sel_flit = '0;
    win      = '0;
    for (int i = 0; i < P; i++) begin
      if (gnt[i]) begin
        sel_flit = bus.flit_in[i*FW +: FW];
        win      = PW'(i);
      end
    end
  end

  assign nxt_ptr = (win == PLAST) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CFULL;
      rr_ptr <= '0;
      wr_q   <= 1'b0;
      flit_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q <= any_gnt;
      if (any_gnt) begin
        flit_q <= sel_flit;
        rr_ptr <= nxt_ptr;
      end
      unique case ({any_gnt, bus.credit_in})
        2'b10: cnt_q <= cnt_q - 1'b1;
        2'b01: begin
          if (cnt_q == CFULL)
            err_q <= 1'b1;
          else
            cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.grant       = gnt;
  assign bus.flit_out_wr = wr_q;
  assign bus.flit_out    = flit_q;
  assign bus.credit_cnt  = cnt_q;
  assign bus.credit_err  = err_q;

endmodule

// File: tb/tb_output_port_ctrl.sv
// Self-checking bench for output_port_ctrl: directed table,
// corner sequences and random traffic against a queue-level model.
module tb_output_port_ctrl;

  localparam int FW = 64;
  localparam int P  = 7;
  localparam int B  = 4;
  localparam int CREDITS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  output_port_ctrl_if #(.FW(FW), .P(P), .B(B)) bus ();

  output_port_ctrl #(.FW(FW), .P(P), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  int       m_cnt;
  int       m_ptr;
  bit       m_err;
  bit       m_wr;
  bit [FW-1:0] m_flit;
  logic [P-1:0] last_grant;

  typedef struct {
    bit       do_rst;
    bit [6:0] req;
    bit       cin;
    bit [6:0] exp_grant;
    bit       exp_wr;
    int       exp_cnt;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_winner(input logic [P-1:0] r);
    if (m_cnt == 0) return -1;
    for (int k = 0; k < P; k++)
      if (r[(m_ptr + k) % P]) return (m_ptr + k) % P;
    return -1;
  endfunction

  task automatic do_reset();
    bus.req_in    = 7'h7F;
    bus.credit_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_grant", 64'(bus.grant), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_cnt", 64'(bus.credit_cnt), 64'(CREDITS));
    chk("rst_wr", 64'(bus.flit_out_wr), 64'd0);
    chk("rst_flit", bus.flit_out, 64'd0);
    chk("rst_err", 64'(bus.credit_err), 64'd0);
    rst = 1'b0;
    m_cnt = CREDITS;
    m_ptr = 0;
    m_err = 0;
    m_wr = 0;
    m_flit = '0;
  endtask

  task automatic step(input logic [P-1:0] r, input logic c);
    int w;
    logic [P-1:0] eg;
    logic [P*FW-1:0] f;
    for (int i = 0; i < P; i++)
      f[i*FW +: FW] = {$urandom, $urandom};
    bus.req_in    = r;
    bus.flit_in   = f;
    bus.credit_in = c;
    #1;
    w  = model_winner(r);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    last_grant = bus.grant;
    chk("grant", 64'(bus.grant), 64'(eg));
    @(posedge clk);
    #1;
    m_wr = (w >= 0);
    if (w >= 0) begin
      m_flit = f[w*FW +: FW];
      m_ptr  = (w + 1) % P;
    end
    if (w >= 0 && !c) m_cnt--;
    else if (c && w < 0) begin
      if (m_cnt == CREDITS) m_err = 1;
      else m_cnt++;
    end
    chk("wr", 64'(bus.flit_out_wr), 64'(m_wr));
    chk("flit", bus.flit_out, m_flit);
    chk("cnt", 64'(bus.credit_cnt), 64'(m_cnt));
    chk("err", 64'(bus.credit_err), 64'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ng;
    bus.req_in    = '0;
    bus.flit_in   = '0;
    bus.credit_in = 1'b0;
    m_cnt = CREDITS; m_ptr = 0; m_err = 0; m_wr = 0; m_flit = '0;

    tv[0] = '{1, 7'b0000100, 0, 7'b0000100, 1, 15};
    tv[1] = '{1, 7'b1000001, 0, 7'b0000001, 1, 15};
    tv[2] = '{0, 7'b1000001, 0, 7'b1000000, 1, 14};
    tv[3] = '{0, 7'b1000001, 0, 7'b0000001, 1, 13};
    tv[4] = '{0, 7'b1000001, 0, 7'b1000000, 1, 12};
    tv[5] = '{0, 7'b0000000, 1, 7'b0000000, 0, 13};
    tv[6] = '{0, 7'b0000010, 1, 7'b0000010, 1, 13};
    tv[7] = '{0, 7'b0000000, 0, 7'b0000000, 0, 13};

    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (tv[i].do_rst) do_reset();
      step(tv[i].req, tv[i].cin);
      chk("tv_grant", 64'(last_grant), 64'(tv[i].exp_grant));
      chk("tv_wr", 64'(bus.flit_out_wr), 64'(tv[i].exp_wr));
      chk("tv_cnt", 64'(bus.credit_cnt), 64'(tv[i].exp_cnt));
    end

    // credits exhausted, then a single returned credit
    do_reset();
    for (int i = 0; i < 16; i++) step(7'h7F, 1'b0);
    chk("exh_cnt", 64'(bus.credit_cnt), 64'd0);
    step(7'h7F, 1'b0);
    chk("exh_nogrant", 64'(last_grant), 64'd0);
    step(7'h7F, 1'b1);
    ng = 0;
    for (int i = 0; i < 3; i++) begin
      step(7'h7F, 1'b0);
      if (last_grant != '0) ng++;
    end
    chk("one_more_grant", 64'(ng), 64'd1);

    // simultaneous grant and credit at 5
    do_reset();
    for (int i = 0; i < 11; i++) step(7'h55, 1'b0);
    chk("cnt5", 64'(bus.credit_cnt), 64'd5);
    step(7'h55, 1'b1);
    chk("both_cnt5", 64'(bus.credit_cnt), 64'd5);

    // overflow is sticky and does not block grants
    do_reset();
    step(7'h00, 1'b1);
    chk("ovf_cnt", 64'(bus.credit_cnt), 64'(CREDITS));
    chk("ovf_err", 64'(bus.credit_err), 64'd1);
    step(7'h08, 1'b0);
    chk("ovf_grant", 64'(last_grant), 64'h08);
    step(7'h00, 1'b1);
    step(7'h00, 1'b0);
    chk("ovf_sticky", 64'(bus.credit_err), 64'd1);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) step(7'h7F, 1'b0);
    bus.req_in = 7'h7F;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_grant", 64'(bus.grant), 64'd0);
    chk("arst_wr", 64'(bus.flit_out_wr), 64'd0);
    chk("arst_cnt", 64'(bus.credit_cnt), 64'(CREDITS));
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = CREDITS; m_ptr = 0; m_err = 0; m_wr = 0; m_flit = '0;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [P-1:0] r;
      logic c;
      r = ($urandom_range(0, 3) == 0) ? '0 : P'($urandom_range(1, 127));
      c = ($urandom_range(0, 2) == 0);
      step(r, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
